// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - multi-channel slide-switch debouncer with edge pulses
module sw_debounce #(
    parameter int SW_SIZE      = 10,
    parameter int TICK_CYCLES  = 1000000,
    parameter int STABLE_TICKS = 4
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic [SW_SIZE-1:0] SW,
    output logic [SW_SIZE-1:0] SW_DB,
    output logic [SW_SIZE-1:0] SW_RISE,
    output logic [SW_SIZE-1:0] SW_FALL,
    output logic               SW_CHANGED
);

    // Counter widths: just wide enough for the terminal value, never below one bit.
    localparam int PW = (TICK_CYCLES  > 1) ? $clog2(TICK_CYCLES)  : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [SW_SIZE-1:0]         sync_meta;
    logic [SW_SIZE-1:0]         sync;
    logic [PW-1:0]              pre;
    logic                       tick;
    logic [SW_SIZE-1:0][CW-1:0] cnt;
    logic [SW_SIZE-1:0][CW-1:0] cnt_next;
    logic [SW_SIZE-1:0]         accept;

    // Two-flop synchronizer bringing the asynchronous pin levels into the clock domain.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= SW;
            sync      <= sync_meta;
        end
    end

    // Shared prescaler; wraps on its last count so the tick period is exactly TICK_CYCLES.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            pre <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // With TICK_CYCLES=1 the prescaler is pinned at zero and every cycle is a tick.
    assign tick = (pre == PRE_LAST);

    // Per-channel qualification: any agreeing sample restarts the count, a full run accepts.
    always_comb begin
        accept   = '0;
        cnt_next = cnt;
        if (tick) begin
            for (int i = 0; i < SW_SIZE; i++) begin
                if (sync[i] == SW_DB[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt_next[i] = '0;
                    accept[i]   = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Qualification counters, held still between ticks.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Debounced levels and edge pulses update together so a pulse marks the first new-value cycle.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            SW_DB      <= '0;
            SW_RISE    <= '0;
            SW_FALL    <= '0;
            SW_CHANGED <= 1'b0;
        end else begin
            SW_DB      <= SW_DB ^ accept;
            SW_RISE    <= accept & sync;
            SW_FALL    <= accept & ~sync;
            SW_CHANGED <= |accept;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce
module tb_sw_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] sw  = '0;
    logic [9:0] sw1 = '0;
    logic [9:0] db, rise, fall;
    logic       chg;
    logic [9:0] db1, rise1, fall1;
    logic       chg1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    sw_debounce #(.SW_SIZE(10), .TICK_CYCLES(4), .STABLE_TICKS(3)) dut (
        .CLOCK_50(clk), .RESET(rst), .SW(sw),
        .SW_DB(db), .SW_RISE(rise), .SW_FALL(fall), .SW_CHANGED(chg)
    );

    sw_debounce #(.SW_SIZE(10), .TICK_CYCLES(1), .STABLE_TICKS(1)) dut_fast (
        .CLOCK_50(clk), .RESET(rst), .SW(sw1),
        .SW_DB(db1), .SW_RISE(rise1), .SW_FALL(fall1), .SW_CHANGED(chg1)
    );

    task automatic do_reset();
        rst = 1'b1;
        sw  = '0;
        sw1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({db, rise, fall, chg} !== 31'b0) begin
            fails++;
            $display("FAIL reset_slow: got db=%h rise=%h fall=%h chg=%b expected all 0", db, rise, fall, chg);
        end
        checks++;
        if ({db1, rise1, fall1, chg1} !== 31'b0) begin
            fails++;
            $display("FAIL reset_fast: got db=%h rise=%h fall=%h chg=%b expected all 0", db1, rise1, fall1, chg1);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if ({db, rise, fall, chg} !== 31'b0) begin
                fails++;
                $display("FAIL idle cyc %0d: got db=%h rise=%h fall=%h chg=%b expected all 0", k, db, rise, fall, chg);
            end
        end
    endtask

    task automatic test_single_rise();
        int n;
        do_reset();
        repeat (5) @(negedge clk);
        sw[0] = 1'b1;
        n = 0;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            @(negedge clk);
            if (db[0]) begin
                n = k;
                checks++;
                if (db !== 10'h001 || rise !== 10'h001 || fall !== 10'h000 || chg !== 1'b1) begin
                    fails++;
                    $display("FAIL rise_pulse: got db=%h rise=%h fall=%h chg=%b expected 001/001/000/1", db, rise, fall, chg);
                end
            end else begin
                checks++;
                if ({db, rise, fall, chg} !== 31'b0) begin
                    fails++;
                    $display("FAIL rise_early cyc %0d: got db=%h rise=%h chg=%b expected 0", k, db, rise, chg);
                end
            end
        end
        checks++;
        if (n < 11 || n > 14) begin
            fails++;
            $display("FAIL rise_latency: got %0d cycles expected 11..14", n);
        end
        @(negedge clk);
        checks++;
        if (db !== 10'h001 || rise !== 10'h000 || chg !== 1'b0) begin
            fails++;
            $display("FAIL rise_after: got db=%h rise=%h chg=%b expected 001/000/0", db, rise, chg);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int c = 0; c < 50; c++) begin
            sw[3] = ((c / 4) % 2 == 0);
            @(negedge clk);
            checks++;
            if ({db, rise, fall, chg} !== 31'b0) begin
                fails++;
                $display("FAIL glitch cyc %0d: got db=%h rise=%h fall=%h chg=%b expected all 0", c, db, rise, fall, chg);
            end
        end
        sw[3] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({db, rise, fall, chg} !== 31'b0) begin
                fails++;
                $display("FAIL glitch_tail cyc %0d: got db=%h chg=%b expected 0", c, db, chg);
            end
        end
    endtask

    task automatic test_all_fall();
        bit done;
        int pulses;
        do_reset();
        sw = 10'h3FF;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (db !== 10'h000) begin
                done = 1'b1;
                checks++;
                if (db !== 10'h3FF || rise !== 10'h3FF || chg !== 1'b1) begin
                    fails++;
                    $display("FAIL all_rise: got db=%h rise=%h chg=%b expected 3ff/3ff/1", db, rise, chg);
                end
            end
        end
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL all_rise_timeout: got db=%h expected 3ff", db);
        end
        @(negedge clk);
        sw = 10'h000;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (chg) pulses++;
            if (db !== 10'h3FF) begin
                checks++;
                if (db !== 10'h000 || (chg && (fall !== 10'h3FF || rise !== 10'h000))) begin
                    fails++;
                    $display("FAIL all_fall cyc %0d: got db=%h fall=%h rise=%h chg=%b expected 000 with fall=3ff", k, db, fall, rise, chg);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL all_fall_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (db !== 10'h000) begin
            fails++;
            $display("FAIL all_fall_final: got %h expected 000", db);
        end
    endtask

    task automatic test_reset_mid();
        int r5;
        logic [9:0] exp_db, exp_rise;
        do_reset();
        sw = 10'h001;
        repeat (12) @(negedge clk);
        checks++;
        if (db !== 10'h001) begin
            fails++;
            $display("FAIL mid_pre: got db=%h expected 001", db);
        end
        sw = 10'h021;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({db, rise, fall, chg} !== 31'b0) begin
            fails++;
            $display("FAIL mid_async: got db=%h rise=%h fall=%h chg=%b expected all 0", db, rise, fall, chg);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({db, rise, fall, chg} !== 31'b0) begin
            fails++;
            $display("FAIL mid_hold: got db=%h chg=%b expected 0", db, chg);
        end
        rst = 1'b0;
        r5 = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (rise[5]) r5++;
            exp_db   = (k >= 12) ? 10'h021 : 10'h000;
            exp_rise = (k == 12) ? 10'h021 : 10'h000;
            checks++;
            if (db !== exp_db || rise !== exp_rise || fall !== 10'h000) begin
                fails++;
                $display("FAIL mid_requal cyc %0d: got db=%h rise=%h fall=%h expected db=%h rise=%h", k, db, rise, fall, exp_db, exp_rise);
            end
        end
        checks++;
        if (r5 != 1) begin
            fails++;
            $display("FAIL mid_rise5_pulses: got %0d expected 1", r5);
        end
    endtask

    task automatic test_fast();
        int n;
        do_reset();
        repeat (3) @(negedge clk);
        sw1[0] = 1'b1;
        n = 0;
        for (int k = 1; k <= 10 && n == 0; k++) begin
            @(negedge clk);
            if (db1[0]) begin
                n = k;
                checks++;
                if (rise1 !== 10'h001 || chg1 !== 1'b1 || fall1 !== 10'h000) begin
                    fails++;
                    $display("FAIL fast_pulse: got rise=%h fall=%h chg=%b expected 001/000/1", rise1, fall1, chg1);
                end
            end
        end
        checks++;
        if (n != 3) begin
            fails++;
            $display("FAIL fast_latency: got %0d cycles expected 3", n);
        end
        @(negedge clk);
        checks++;
        if (db1 !== 10'h001 || rise1 !== 10'h000 || chg1 !== 1'b0) begin
            fails++;
            $display("FAIL fast_after: got db=%h rise=%h chg=%b expected 001/000/0", db1, rise1, chg1);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_rise();
        test_glitch();
        test_all_fall();
        test_reset_mid();
        test_fast();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
